// File: rtl/multicycle_control32_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// constants and the pc_src / reg_dst select codes.
package multicycle_control32_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
  localparam logic [5:0] FnSllv = 6'b000100;
  localparam logic [5:0] FnSrlv = 6'b000110;
  localparam logic [5:0] FnSrav = 6'b000111;
  localparam logic [5:0] FnJr   = 6'b001000;

  localparam logic [1:0] PcSrcPlus4  = 2'b00;
  localparam logic [1:0] PcSrcBranch = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcRs     = 2'b11;

  localparam logic [1:0] RegDstRt = 2'b00;
  localparam logic [1:0] RegDstRd = 2'b01;
  localparam logic [1:0] RegDstRa = 2'b10;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/control_decode32.sv
// Pure combinational opcode/funct decode, same instruction classes as control32.
module control_decode32
  import multicycle_control32_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       r_format,
  output logic       i_format,
  output logic       lw,
  output logic       sw,
  output logic       beq,
  output logic       bne,
  output logic       j,
  output logic       jal,
  output logic       jr,
  output logic       sftmd,
  output logic [1:0] alu_op
);

  always_comb begin
    r_format = (opcode == OpRType);
    i_format = (opcode[5:3] == 3'b001);
    lw       = (opcode == OpLw);
    sw       = (opcode == OpSw);
    beq      = (opcode == OpBeq);
    bne      = (opcode == OpBne);
    j        = (opcode == OpJ);
    jal      = (opcode == OpJal);
    jr       = r_format && (funct == FnJr);
    sftmd    = r_format && (funct inside {FnSll, FnSrl, FnSra, FnSllv, FnSrlv, FnSrav});
    alu_op   = {r_format | i_format, beq | bne};
  end

endmodule

// File: rtl/multicycle_control32.sv
// Multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with parametrised memory latency,
// I/O window with ready handshake and timeout, and a UART-download hold in FETCH.
module multicycle_control32
  import multicycle_control32_pkg::*;
#(
  parameter int unsigned          ADDR_HI_W  = 22,
  parameter logic [ADDR_HI_W-1:0] IO_HIGH    = 22'h3FFFFF,
  parameter int unsigned          IMEM_LAT   = 1,
  parameter int unsigned          DMEM_LAT   = 1,
  parameter int unsigned          IO_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic [ADDR_HI_W-1:0] alu_result_high,
  input  logic                 zero,
  input  logic                 io_ready,
  input  logic                 uart_hold,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg_write,
  output logic [1:0]           reg_dst,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 io_read,
  output logic                 io_write,
  output logic                 memorio_to_reg,
  output logic                 alu_src,
  output logic                 sftmd,
  output logic                 i_format,
  output logic [1:0]           alu_op,
  output logic                 io_timeout,
  output logic [2:0]           state
);

  localparam int unsigned CntMax = max3(IMEM_LAT, DMEM_LAT, IO_TIMEOUT);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            io_timeout_q, io_timeout_d;

  logic dec_r, dec_i, dec_lw, dec_sw, dec_beq, dec_bne, dec_j, dec_jal, dec_jr;

  control_decode32 u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .r_format (dec_r),
    .i_format (dec_i),
    .lw       (dec_lw),
    .sw       (dec_sw),
    .beq      (dec_beq),
    .bne      (dec_bne),
    .j        (dec_j),
    .jal      (dec_jal),
    .jr       (dec_jr),
    .sftmd    (sftmd),
    .alu_op   (alu_op)
  );

  logic fetch_last, dmem_last, io_last, mem_is_io, io_fail, mem_done;
  logic take_branch, is_jump, is_branch, exec_known;

  always_comb begin
    fetch_last  = (cnt_q == CntW'(IMEM_LAT - 1));
    dmem_last   = (cnt_q == CntW'(DMEM_LAT - 1));
    io_last     = (cnt_q == CntW'(IO_TIMEOUT - 1));
    mem_is_io   = (alu_result_high == IO_HIGH);
    // A ready arriving on the final allowed cycle still counts as success.
    io_fail     = mem_is_io && !io_ready && io_last;
    mem_done    = mem_is_io ? (io_ready || io_last) : dmem_last;
    is_jump     = dec_j || dec_jal || dec_jr;
    is_branch   = dec_beq || dec_bne;
    take_branch = (dec_beq && zero) || (dec_bne && !zero);
    exec_known  = dec_r || dec_i || dec_lw || dec_sw;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StFetch;
      cnt_q        <= '0;
      io_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      io_timeout_q <= io_timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    io_timeout_d = io_timeout_q;
    cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
    case (state_q)
      StFetch: begin
        if (uart_hold) begin
          cnt_d = '0;
        end else if (fetch_last) begin
          state_d = StDecode;
        end
      end
      StDecode: state_d = is_jump ? StFetch : StExec;
      StExec: begin
        if (is_branch) begin
          state_d = StFetch;
        end else if (dec_r || dec_i) begin
          state_d = StWb;
        end else if (dec_lw || dec_sw) begin
          state_d = StMem;
        end else begin
          state_d = StFetch;
        end
      end
      StMem: begin
        if (mem_done) begin
          if (io_fail) begin
            io_timeout_d = 1'b1;
            state_d      = StFetch;
          end else begin
            state_d = dec_lw ? StWb : StFetch;
          end
        end
      end
      StWb:    state_d = StFetch;
      default: state_d = StFetch;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = PcSrcPlus4;
    reg_write      = 1'b0;
    reg_dst        = RegDstRt;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    io_read        = 1'b0;
    io_write       = 1'b0;
    memorio_to_reg = 1'b0;
    case (state_q)
      StFetch: ir_write = !uart_hold && fetch_last;
      StDecode: begin
        if (is_jump) begin
          pc_write = 1'b1;
          pc_src   = dec_jr ? PcSrcRs : PcSrcJump;
          if (dec_jal) begin
            reg_write = 1'b1;
            reg_dst   = RegDstRa;
          end
        end
      end
      StExec: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_src   = take_branch ? PcSrcBranch : PcSrcPlus4;
        end else if (!exec_known) begin
          pc_write = 1'b1;
        end
      end
      StMem: begin
        io_read   = mem_is_io && dec_lw;
        io_write  = mem_is_io && dec_sw;
        mem_read  = !mem_is_io && dec_lw;
        mem_write = !mem_is_io && dec_sw;
        pc_write  = mem_done && (dec_sw || io_fail);
      end
      StWb: begin
        reg_write      = 1'b1;
        reg_dst        = dec_r ? RegDstRd : RegDstRt;
        memorio_to_reg = dec_lw;
        pc_write       = 1'b1;
      end
      default: ;
    endcase
    // Strobes are forced low for the whole reset cycle, not just after the edge.
    if (!reset_n) begin
      ir_write       = 1'b0;
      pc_write       = 1'b0;
      pc_src         = PcSrcPlus4;
      reg_write      = 1'b0;
      reg_dst        = RegDstRt;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      io_read        = 1'b0;
      io_write       = 1'b0;
      memorio_to_reg = 1'b0;
    end
  end

  assign alu_src    = dec_i || dec_lw || dec_sw;
  assign i_format   = dec_i;
  assign io_timeout = io_timeout_q;
  assign state      = state_q;

endmodule
